// File: rtl/ssp_pkg.sv
// Shared types and constants for the SSP transmit scheduler.
package ssp_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } ssp_state_e;

    localparam logic SRC0 = 1'b0;
    localparam logic SRC1 = 1'b1;

    localparam int unsigned SSP_WORD_W = 8;

endpackage

// File: rtl/ssp_clk_gen.sv
// Free-running SSP clock divider; fall_tick_o marks the cycle before ssp_clk falls.
module ssp_clk_gen #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    output logic ssp_clk_o,
    output logic fall_tick_o
);

    localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic             ssp_clk_q, ssp_clk_d;
    logic             wrap;

    always_comb begin
        wrap      = (div_cnt_q == DIV_LAST);
        div_cnt_d = wrap ? '0 : div_cnt_q + 1'b1;
        ssp_clk_d = wrap ? ~ssp_clk_q : ssp_clk_q;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            div_cnt_q <= '0;
            ssp_clk_q <= 1'b0;
        end else begin
            div_cnt_q <= div_cnt_d;
            ssp_clk_q <= ssp_clk_d;
        end
    end

    assign ssp_clk_o   = ssp_clk_q;
    assign fall_tick_o = wrap && ssp_clk_q;

endmodule

// File: rtl/ssp_tx_sched.sv
// Round-robin arbiter between two word sources feeding an MSB-first SSP serializer.
module ssp_tx_sched
    import ssp_pkg::*;
#(
    parameter int unsigned CLK_DIV = 4,
    parameter int unsigned WORD_W  = SSP_WORD_W,
    parameter int unsigned CNT_W   = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              src0_valid,
    input  logic [WORD_W-1:0] src0_data,
    output logic              src0_ready,
    input  logic              src1_valid,
    input  logic [WORD_W-1:0] src1_data,
    output logic              src1_ready,
    output logic              ssp_clk,
    output logic              ssp_frame,
    output logic              ssp_din,
    output logic              busy,
    output logic [CNT_W-1:0]  words_sent
);

    localparam int unsigned IDX_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;

    ssp_state_e        state_q, state_d;
    logic [WORD_W-1:0] shreg_q, shreg_d;
    logic [IDX_W-1:0]  bit_idx_q, bit_idx_d;
    logic              last_grant_q, last_grant_d;
    logic              frame_q, frame_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic              fall_tick;
    logic              slot_open;
    logic              grant0, grant1;

    ssp_clk_gen #(
        .CLK_DIV(CLK_DIV)
    ) u_clk_gen (
        .clk_i      (clk),
        .rst_i      (reset),
        .ssp_clk_o  (ssp_clk),
        .fall_tick_o(fall_tick)
    );

    // A slot opens when idle or on the last bit, so back-to-back words need no gap.
    always_comb begin
        slot_open = fall_tick && enable && (state_q == IDLE || bit_idx_q == '0);
        grant0    = slot_open && src0_valid && (!src1_valid || last_grant_q == SRC1);
        grant1    = slot_open && src1_valid && (!src0_valid || last_grant_q == SRC0);
    end

    always_comb begin
        state_d      = state_q;
        shreg_d      = shreg_q;
        bit_idx_d    = bit_idx_q;
        last_grant_d = last_grant_q;
        frame_d      = frame_q;
        cnt_d        = cnt_q;

        if (fall_tick) begin
            if (grant0 || grant1) begin
                shreg_d      = grant1 ? src1_data : src0_data;
                bit_idx_d    = IDX_W'(WORD_W - 1);
                last_grant_d = grant1 ? SRC1 : SRC0;
                frame_d      = 1'b1;
                state_d      = SHIFT;
                if (cnt_q != '1) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end else if (state_q == SHIFT && bit_idx_q != '0) begin
                shreg_d   = shreg_q << 1;
                bit_idx_d = bit_idx_q - 1'b1;
                frame_d   = 1'b0;
            end else begin
                shreg_d = '0;
                frame_d = 1'b0;
                state_d = IDLE;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            shreg_q      <= '0;
            bit_idx_q    <= '0;
            last_grant_q <= SRC1;
            frame_q      <= 1'b0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            shreg_q      <= shreg_d;
            bit_idx_q    <= bit_idx_d;
            last_grant_q <= last_grant_d;
            frame_q      <= frame_d;
            cnt_q        <= cnt_d;
        end
    end

    // The shift register is cleared on entry to IDLE, so its MSB doubles as ssp_din.
    assign ssp_din    = shreg_q[WORD_W-1];
    assign ssp_frame  = frame_q;
    assign busy       = (state_q == SHIFT);
    assign words_sent = cnt_q;
    assign src0_ready = grant0;
    assign src1_ready = grant1;

endmodule

// File: tb/tb_ssp_tx_sched.sv
// Randomized and directed bench for ssp_tx_sched against a slot-level reference model.
module tb_ssp_tx_sched;

    localparam int unsigned CLK_DIV = 4;
    localparam int unsigned WORD_W  = 8;
    localparam int unsigned TICK    = 2 * CLK_DIV;

    logic              clk;
    logic              reset;
    logic              enable;
    logic              src0_valid, src1_valid;
    logic [WORD_W-1:0] src0_data, src1_data;
    logic              src0_ready, src1_ready;
    logic              ssp_clk, ssp_frame, ssp_din, busy;
    logic [15:0]       words_sent;
    logic              b_src0_ready, b_src1_ready;
    logic              b_ssp_clk, b_ssp_frame, b_ssp_din, b_busy;
    logic [3:0]        b_words_sent;

    ssp_tx_sched #(.CLK_DIV(CLK_DIV), .WORD_W(WORD_W), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .enable(enable),
        .src0_valid(src0_valid), .src0_data(src0_data), .src0_ready(src0_ready),
        .src1_valid(src1_valid), .src1_data(src1_data), .src1_ready(src1_ready),
        .ssp_clk(ssp_clk), .ssp_frame(ssp_frame), .ssp_din(ssp_din),
        .busy(busy), .words_sent(words_sent)
    );

    ssp_tx_sched #(.CLK_DIV(CLK_DIV), .WORD_W(WORD_W), .CNT_W(4)) dut_sat (
        .clk(clk), .reset(reset), .enable(enable),
        .src0_valid(src0_valid), .src0_data(src0_data), .src0_ready(b_src0_ready),
        .src1_valid(src1_valid), .src1_data(src1_data), .src1_ready(b_src1_ready),
        .ssp_clk(b_ssp_clk), .ssp_frame(b_ssp_frame), .ssp_din(b_ssp_din),
        .busy(b_busy), .words_sent(b_words_sent)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    // Reference model: slot-level view of the link.
    int unsigned       e;          // posedges since reset release
    int unsigned       m_rem;      // bit periods left in current word (0 = idle)
    logic [WORD_W-1:0] m_word;
    logic              m_last;
    int unsigned       m_cnt, m_cnt4;
    logic              g0_prev, g1_prev;

    // Stimulus state
    logic [WORD_W-1:0] q0[$], q1[$];
    logic [WORD_W-1:0] got[$];
    logic              hold0, hold1;
    bit                cont, rnd;
    int unsigned       rdy0_cnt, rdy1_cnt;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        e = 0; m_rem = 0; m_word = '0; m_last = 1'b1;
        m_cnt = 0; m_cnt4 = 0; g0_prev = 1'b0; g1_prev = 1'b0;
    endtask

    task automatic drive_sources();
        if (g0_prev && q0.size() > 0) void'(q0.pop_front());
        if (g1_prev && q1.size() > 0) void'(q1.pop_front());
        if (cont) begin
            if (q0.size() == 0) q0.push_back(8'h11);
            if (q1.size() == 0) q1.push_back(8'h22);
        end
        if (rnd) begin
            if (q0.size() < 2 && $urandom_range(0, 7) == 0) q0.push_back(WORD_W'($urandom));
            if (q1.size() < 2 && $urandom_range(0, 7) == 0) q1.push_back(WORD_W'($urandom));
            if ($urandom_range(0, 31) == 0) hold0 = ~hold0;
            if ($urandom_range(0, 31) == 0) hold1 = ~hold1;
            if ($urandom_range(0, 99) == 0) enable = ~enable;
        end
        src0_valid = (q0.size() > 0) && hold0;
        src1_valid = (q1.size() > 0) && hold1;
        src0_data  = (q0.size() > 0) ? q0[0] : '0;
        src1_data  = (q1.size() > 0) ? q1[0] : '0;
    endtask

    // Called at a negedge; returns at the following negedge.
    task automatic step();
        logic tick, g0, g1, exp_din;
        exp_din = (m_rem != 0) ? m_word[m_rem-1] : 1'b0;
        chk("ssp_clk", ssp_clk, ((e / CLK_DIV) % 2) == 1);
        chk("busy", busy, m_rem != 0);
        chk("ssp_frame", ssp_frame, m_rem == WORD_W);
        chk("ssp_din", ssp_din, exp_din);
        chk("words_sent", words_sent, m_cnt);
        chk("words_sent_sat", b_words_sent, m_cnt4);
        drive_sources();
        #1;
        tick = ((e + 1) % TICK) == 0;
        g0 = 1'b0;
        g1 = 1'b0;
        if (tick && enable && m_rem <= 1) begin
            if (src0_valid && (!src1_valid || m_last)) g0 = 1'b1;
            else if (src1_valid) g1 = 1'b1;
        end
        chk("src0_ready", src0_ready, g0);
        chk("src1_ready", src1_ready, g1);
        if (src0_ready) begin rdy0_cnt++; got.push_back(src0_data); end
        if (src1_ready) begin rdy1_cnt++; got.push_back(src1_data); end
        if (tick) begin
            if (g0 || g1) begin
                m_word = g0 ? src0_data : src1_data;
                m_rem  = WORD_W;
                m_last = g1;
                if (m_cnt != 65535) m_cnt++;
                if (m_cnt4 != 15) m_cnt4++;
            end else if (m_rem > 0) begin
                m_rem--;
            end
        end
        g0_prev = g0;
        g1_prev = g1;
        e++;
        @(negedge clk);
    endtask

    task automatic run(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) step();
    endtask

    task automatic run_until_rem(input int unsigned target, input int unsigned budget);
        int unsigned k;
        k = 0;
        while (m_rem != target && k < budget) begin
            step();
            k++;
        end
        chk("wait_bit_position", m_rem, target);
    endtask

    // Entered at a negedge; asserts reset mid-phase and checks outputs before any edge.
    task automatic do_reset();
        #2;
        reset = 1'b1;
        #1;
        chk("rst_ssp_clk", ssp_clk, 0);
        chk("rst_frame", ssp_frame, 0);
        chk("rst_din", ssp_din, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ready0", src0_ready, 0);
        chk("rst_ready1", src1_ready, 0);
        chk("rst_words", words_sent, 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [WORD_W-1:0] exp_b[4];
        logic [WORD_W-1:0] exp_c[3];
        exp_b = '{8'h11, 8'h22, 8'h11, 8'h22};
        exp_c = '{8'h01, 8'h80, 8'hFF};
        reset = 1'b1; enable = 1'b1;
        src0_valid = 1'b0; src1_valid = 1'b0; src0_data = '0; src1_data = '0;
        hold0 = 1'b1; hold1 = 1'b1; cont = 1'b0; rnd = 1'b0;
        model_reset();
        @(negedge clk);

        // Single word 0xA5 from src0
        do_reset();
        q0.push_back(8'hA5);
        rdy0_cnt = 0; rdy1_cnt = 0;
        run(2 * WORD_W * TICK + 8);
        chk("a5_ready_pulses", rdy0_cnt, 1);
        chk("a5_words_sent", words_sent, 1);

        // Both sources continuously valid
        do_reset();
        got.delete(); cont = 1'b1;
        run(4 * WORD_W * TICK + TICK + 1);
        cont = 1'b0; q0.delete(); q1.delete();
        chk("rr_count_ge4", got.size() >= 4, 1);
        for (int i = 0; i < 4; i++)
            if (got.size() > i) chk("rr_order", got[i], exp_b[i]);

        // src1 alone, three words
        do_reset();
        got.delete();
        foreach (exp_c[i]) q1.push_back(exp_c[i]);
        run(3 * WORD_W * TICK + 2 * TICK);
        chk("src1_count", got.size(), 3);
        for (int i = 0; i < 3; i++)
            if (got.size() > i) chk("src1_order", got[i], exp_c[i]);

        // enable dropped mid-word
        do_reset();
        got.delete();
        q0.push_back(8'hC3); q0.push_back(8'hA1);
        run_until_rem(WORD_W - 2, 200);
        enable = 1'b0;
        rdy0_cnt = 0; rdy1_cnt = 0;
        run(200);
        chk("dis_no_ready", rdy0_cnt + rdy1_cnt, 0);
        chk("dis_only_c3", got.size(), 1);
        enable = 1'b1;
        run(3 * TICK);
        chk("en_resume_count", got.size(), 2);
        if (got.size() > 1) chk("en_resume_word", got[1], 8'hA1);
        q0.delete();

        // Reset mid-word, then tie goes to src0
        do_reset();
        q0.push_back(8'h5A); q1.push_back(8'h3C);
        run_until_rem(5, 200);
        q0.delete(); q0.push_back(8'h77);
        do_reset();
        got.delete();
        run(TICK + 2);
        chk("post_rst_tie_src0", got.size() > 0 ? got[0] : 8'h00, 8'h77);
        run(WORD_W * TICK);
        q0.delete(); q1.delete();

        // Randomized traffic
        do_reset();
        rnd = 1'b1;
        run(3000);
        rnd = 1'b0; enable = 1'b1; hold0 = 1'b1; hold1 = 1'b1;
        q0.delete(); q1.delete();

        // Counter saturation on the 4-bit instance
        do_reset();
        cont = 1'b1;
        for (int k = 0; k < 2000 && m_cnt < 20; k++) step();
        run(10);
        cont = 1'b0;
        chk("sat_reached_20", m_cnt >= 20, 1);
        chk("sat_hold_15", b_words_sent, 4'hF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ssp_tx_sched.md
Name: ssp_tx_sched

Overview:
Shares the FPGA→ARM SSP link between two word-producing sources, for example hi-mode demodulator output and a test/status pattern source. It round-robin arbitrates between the sources and serializes each granted word MSB-first onto ssp_din. It generates a free-running ssp_clk by dividing the system clock, and pulses ssp_frame for the first bit of each word. It sits between the mode modules and the top-level SSP output pins and replaces the ad-hoc per-mode SSP muxing.

Parameters:
CLK_DIV, 4, system clocks per ssp_clk half-period; must be ≥1 (4 gives ssp_clk = clk/8).
WORD_W, 8, bits per SSP word.
CNT_W, 16, width of the words_sent counter.

Ports:
clk  in  1  system clock (ck_1356meg domain).
reset  in  1  asynchronous active-high reset.
enable  in  1  permits new grants; a word already in flight always completes.
src0_valid  in  1  source 0 has a word.
src0_data  in  WORD_W  source 0 word; held stable while src0_valid && !src0_ready.
src0_ready  out  1  combinational; a transfer occurs at a clock edge where valid && ready.
src1_valid  in  1  source 1 has a word.
src1_data  in  WORD_W  source 1 word.
src1_ready  out  1  as src0_ready.
ssp_clk  out  1  serial clock to the ARM; the ARM samples on the rising edge.
ssp_frame  out  1  high during the first bit period of each word.
ssp_din  out  1  serial data to the ARM.
busy  out  1  high while a word is being shifted.
words_sent  out  CNT_W  count of words loaded; saturates at all-ones.

Behaviour:
- Reset (asynchronous, immediate, including mid-word): ssp_clk=0, ssp_frame=0, ssp_din=0, busy=0, ready outputs=0, words_sent=0, div_cnt=0, state=IDLE, last_grant=1 (so src0 wins the first tie). The partially sent word is discarded with no ready pulse.
- Clock divider:
  - div_cnt counts 0..CLK_DIV-1.
  - When div_cnt==CLK_DIV-1, div_cnt wraps to 0 and ssp_clk toggles.
  - fall_tick = (div_cnt==CLK_DIV-1) && ssp_clk==1.
  - The first fall_tick occurs at clock edge 2*CLK_DIV after reset release.
  - ssp_clk runs continuously whether or not data is sent.
- All of ssp_din, ssp_frame, busy, state and words_sent update only on fall_tick edges. Data therefore changes on falling ssp_clk and is stable across the rising edge.
- Grant decision (combinational, evaluated only when fall_tick && enable && (state==IDLE or bit_idx==0)):
  - Only one source valid: grant that source.
  - Both valid: grant the source != last_grant.
  - The granted srcN_ready is 1 for that single cycle; all other ready outputs are 0.
- States:
  - IDLE:
    - ssp_frame=0, ssp_din=0, busy=0.
    - On a fall_tick with a grant: load shreg=data, drive ssp_din=data[WORD_W-1], ssp_frame=1, busy=1, bit_idx=WORD_W-1, last_grant=granted, words_sent+1 (saturating), go to SHIFT.
  - SHIFT, on each fall_tick:
    - If bit_idx>0: ssp_frame=0, bit_idx-1, ssp_din=next bit.
    - If bit_idx==0 and a grant exists: load the new word exactly as from IDLE, with no idle gap (back-to-back framing).
    - If bit_idx==0 and no grant: go to IDLE, ssp_din=0, ssp_frame=0, busy=0.
- Latency: valid asserted ≥1 clk before a qualifying fall_tick puts the MSB on ssp_din at that edge. Each word occupies WORD_W*2*CLK_DIV clocks.
- enable deasserted:
  - mid-word: the word finishes, then the block goes to IDLE.
  - in IDLE: no grants, and valid sources wait.
- Valid dropping before ready is permitted; the source simply loses that slot.
- words_sent at all-ones stays at all-ones.

Decomposition:
- Shared package ssp_pkg:
  - state enum {IDLE, SHIFT}
  - source ID constants SRC0=0, SRC1=1
  - default WORD_W
- One sub-module, ssp_clk_gen (parameter CLK_DIV; outputs ssp_clk and fall_tick), instantiated once.
- Arbitration and shifting stay in ssp_tx_sched.

Test Plan:
- CLK_DIV=4, src0 sends 0xA5 once → ssp_frame high for 8 clks. ssp_din reads 1,0,1,0,0,1,0,1, 8 clks per bit, changing on ssp_clk falling edges. src0_ready pulses exactly once. words_sent=1, then IDLE with din=0.
- src0 and src1 both continuously valid with 0x11 and 0x22 → words sent in the order 0x11, 0x22, 0x11, 0x22, with a frame every 64 clks and no gap. Each ready pulse lands on a fall_tick.
- Only src1 valid, 3 words (0x01, 0x80, 0xFF) → all three are granted to src1 back-to-back. ssp_din matches MSB-first order.
- enable dropped 2 bits into 0xC3 with src0 still valid → 0xC3 completes all 8 bits. No further ready or frame until enable rises again, after which the next word starts at the next fall_tick.
- reset asserted mid-word → all outputs go to 0 immediately, with no clock edge needed. After release, the first frame appears at the 2*CLK_DIV edge, and src0 wins the tie.
- CNT_W=4, 20 words sent → words_sent reads 15 and holds at 15.
